pattern_det_ctrl: RTL and testbench

- Frame-level controller for the serial pattern detector datapath.
- Accepts configuration (pattern bits, pattern length, frame length) and a start command.
- Pulls parallel words over a valid/ready handshake, serializes them MSB-first one bit per cycle into a non-overlapping Moore-style matcher, and counts detections.
- Reports completion with a done pulse and a saturating match count; sits between the bus/config logic and the bit-serial detector.

---
 rtl/pattern_det_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pattern_det_ctrl.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_det_ctrl.sv
// Frame controller that serializes words MSB-first into a pattern matcher.
// Define PATTERN_DET_OVERLAP_EN to add cfg_overlap (overlapping matches).
module pattern_det_ctrl #(
    parameter int PAT_W  = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8,
    parameter int FLEN_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic [3:0]        cfg_len,
`ifdef PATTERN_DET_OVERLAP_EN
    input  logic              cfg_overlap,
`endif
    input  logic              start,
    input  logic              abort,
    input  logic [FLEN_W-1:0] frame_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_count,
    output logic              overflow,
    output logic              done
);

    localparam int HC_W = $clog2(PAT_W + 1);
    localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state;
    logic [PAT_W-1:0]  pat_q;
    logic [3:0]        len_q;
    logic [FLEN_W-1:0] flen_q;
    logic [FLEN_W-1:0] wcnt;
    logic [DATA_W-1:0] word_q;
    logic [BC_W-1:0]   bcnt;
    logic [PAT_W-2:0]  hist;
    logic [HC_W-1:0]   hcnt;
    logic              ovl_q;

    logic              bit_in;
    logic [PAT_W-1:0]  hist_nxt;
    logic [PAT_W-1:0]  mask;
    logic [HC_W-1:0]   hcnt_inc;
    logic              len_ok;
    logic              hit;
    logic              last_bit;

    assign in_ready = (state == S_LOAD);
    assign busy     = (state != S_IDLE);

    assign bit_in   = word_q[DATA_W-1];
    assign hist_nxt = {hist, bit_in};
    assign hcnt_inc = (hcnt == HC_W'(PAT_W)) ? hcnt : hcnt + 1'b1;
    assign len_ok   = (len_q != 4'd0) && (int'(len_q) <= PAT_W);
    assign last_bit = (bcnt == BC_W'(DATA_W - 1));

    always_comb begin
        mask = '0;
        for (int k = 0; k < PAT_W; k++) begin
            mask[k] = (k < int'(len_q));
        end
    end

    assign hit = (int'(hcnt) + 1 >= int'(len_q)) &&
                 (((hist_nxt ^ pat_q) & mask) == '0);

`ifndef PATTERN_DET_OVERLAP_EN
    assign ovl_q = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            flen_q      <= '0;
            wcnt        <= '0;
            word_q      <= '0;
            bcnt        <= '0;
            hist        <= '0;
            hcnt        <= '0;
            match_pulse <= 1'b0;
            match_count <= '0;
            overflow    <= 1'b0;
            done        <= 1'b0;
`ifdef PATTERN_DET_OVERLAP_EN
            ovl_q       <= 1'b0;
`endif
        end else begin
            match_pulse <= 1'b0;
            done        <= 1'b0;

            if (cfg_we && state == S_IDLE) begin
                pat_q <= cfg_pattern;
                len_q <= cfg_len;
`ifdef PATTERN_DET_OVERLAP_EN
                ovl_q <= cfg_overlap;
`endif
            end

            // abort wins over any handshake or match in the same cycle
            if (abort && state != S_IDLE) begin
                state <= S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start && len_ok) begin
                            match_count <= '0;
                            overflow    <= 1'b0;
                            hist        <= '0;
                            hcnt        <= '0;
                            wcnt        <= '0;
                            flen_q      <= frame_len;
                            if (frame_len == '0) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (in_valid) begin
                            word_q <= in_data;
                            bcnt   <= '0;
                            state  <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        word_q <= {word_q[DATA_W-2:0], 1'b0};
                        bcnt   <= bcnt + 1'b1;
                        if (hit) begin
                            match_pulse <= 1'b1;
                            if (&match_count) begin
                                overflow <= 1'b1;
                            end else begin
                                match_count <= match_count + 1'b1;
                            end
                        end
                        // non-overlapping mode restarts matching after a hit
                        if (hit && !ovl_q) begin
                            hist <= '0;
                            hcnt <= '0;
                        end else begin
                            hist <= hist_nxt[PAT_W-2:0];
                            hcnt <= hcnt_inc;
                        end
                        if (last_bit) begin
                            wcnt <= wcnt + 1'b1;
                            if ((wcnt + 1'b1) == flen_q) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= S_LOAD;
                            end
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Bench for pattern_det_ctrl: directed scenarios plus random frames
// checked against a bit-queue reference model.
module tb_pattern_det_ctrl;

    localparam int PW = 8;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int FW = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_we = 1'b0;
    logic [PW-1:0] cfg_pattern = '0;
    logic [3:0]    cfg_len = '0;
`ifdef PATTERN_DET_OVERLAP_EN
    logic          cfg_overlap = 1'b0;
`endif
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [FW-1:0] frame_len = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          busy;
    logic          match_pulse;
    logic [CW-1:0] match_count;
    logic          overflow;
    logic          done;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] frm_words[$];
    int            frm_gaps[$];
    logic [PW-1:0] m_pat;
    int            m_len;
    bit            m_ovl;
    int            exp_bits[$];
    int            exp_cnt;
    bit            exp_ovf;

    int obs_acc[$];
    int obs_pulses[$];
    int obs_dones[$];
    bit obs_busy_bad;
    bit obs_timeout;

    pattern_det_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
`ifdef PATTERN_DET_OVERLAP_EN
        .cfg_overlap (cfg_overlap),
`endif
        .start       (start),
        .abort       (abort),
        .frame_len   (frame_len),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .busy        (busy),
        .match_pulse (match_pulse),
        .match_count (match_count),
        .overflow    (overflow),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [PW-1:0] p, input int l, input bit o);
        cfg_we = 1'b1;
        cfg_pattern = p;
        cfg_len = 4'(l);
`ifdef PATTERN_DET_OVERLAP_EN
        cfg_overlap = o;
        m_ovl = o;
`else
        m_ovl = 1'b0;
`endif
        tick();
        cfg_we = 1'b0;
        m_pat = p;
        m_len = l;
    endtask

    // Reference: keep the bits seen since the last restart and test the tail.
    function automatic void model(input int flen);
        bit q[$];
        bit ok;
        exp_bits.delete();
        exp_cnt = 0;
        exp_ovf = 1'b0;
        for (int w = 0; w < flen; w++) begin
            for (int i = 0; i < DW; i++) begin
                q.push_back(frm_words[w][DW-1-i]);
                if (q.size() >= m_len) begin
                    ok = 1'b1;
                    for (int k = 0; k < m_len; k++)
                        if (q[q.size()-1-k] != m_pat[k]) ok = 1'b0;
                    if (ok) begin
                        exp_bits.push_back(w * DW + i);
                        if (exp_cnt == CMAX) exp_ovf = 1'b1;
                        else exp_cnt++;
                        if (!m_ovl) q.delete();
                    end
                end
            end
        end
    endfunction

    // Drive one frame; edge numbers are counted from the start edge (=1).
    task automatic run_frame(input int flen, input bit junk);
        int e = 0;
        int w = 0;
        int gap_left = 0;
        bit rdy = 1'b0;
        bit drv = 1'b0;
        bit fin = 1'b0;
        obs_acc.delete();
        obs_pulses.delete();
        obs_dones.delete();
        obs_busy_bad = 1'b0;
        if (flen > 0) gap_left = frm_gaps[0];
        frame_len = FW'(flen);
        start = 1'b1;
        while (!fin && e < 4000) begin
            @(posedge clk);
            e++;
            if (drv && rdy) begin
                obs_acc.push_back(e);
                w++;
                if (w < flen) gap_left = frm_gaps[w];
            end
            #1;
            start = 1'b0;
            cfg_we = junk && (e == 3);
            cfg_pattern = PW'($urandom);
            cfg_len = 4'($urandom);
            rdy = in_ready;
            if (match_pulse) obs_pulses.push_back(e);
            if (done) obs_dones.push_back(e);
            if (obs_dones.size() == 0 && !busy) obs_busy_bad = 1'b1;
            if (obs_dones.size() > 0 && e > obs_dones[0]) fin = 1'b1;
            drv = rdy && (w < flen) && (gap_left == 0);
            if (rdy && w < flen && gap_left > 0) gap_left--;
            in_valid = drv;
            in_data = drv ? frm_words[w] : DW'($urandom);
        end
        in_valid = 1'b0;
        cfg_we = 1'b0;
        obs_timeout = !fin;
    endtask

    task automatic test_reset;
        #2;
        total++;
        if ({busy, in_ready, match_pulse, done, overflow, match_count} !== '0) begin
            bad++;
            $display("FAIL reset_init got busy=%b rdy=%b cnt=%0d req all 0", busy, in_ready, match_count);
        end
        tick();
        rst = 1'b1;
        tick();
        set_cfg(8'b0000_1011, 4, 1'b0);
        start = 1'b1;
        frame_len = 1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hBB;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        total++;
        if (match_count !== 8'd1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_preframe got cnt=%0d busy=%b req cnt=1 busy=1", match_count, busy);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({busy, in_ready, match_pulse, done, overflow, match_count} !== '0) begin
            bad++;
            $display("FAIL reset_async got busy=%b rdy=%b cnt=%0d req all 0", busy, in_ready, match_count);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        total++;
        if ({busy, in_ready, match_pulse, done, overflow, match_count} !== '0) begin
            bad++;
            $display("FAIL reset_release got busy=%b rdy=%b cnt=%0d req all 0", busy, in_ready, match_count);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_cfg_cleared got busy=%b req 0", busy);
        end
    endtask

    task automatic test_basic;
        set_cfg(8'b0000_1011, 4, 1'b0);
        frm_words = '{8'b1011_1011};
        frm_gaps = '{0};
        run_frame(1, 1'b0);
        total++;
        if (obs_timeout || obs_acc.size() != 1) begin
            bad++;
            $display("FAIL basic_bb_run timeout=%b acc=%0d req 0/1", obs_timeout, obs_acc.size());
        end else begin
            total++;
            if (match_count !== 8'd2 || obs_pulses.size() != 2) begin
                bad++;
                $display("FAIL basic_bb_count got cnt=%0d pulses=%0d req 2/2", match_count, obs_pulses.size());
            end else if (obs_pulses[0] != obs_acc[0] + 4 || obs_pulses[1] != obs_acc[0] + 8) begin
                bad++;
                $display("FAIL basic_bb_pulse got %0d,%0d req %0d,%0d", obs_pulses[0], obs_pulses[1],
                         obs_acc[0] + 4, obs_acc[0] + 8);
            end
            total++;
            if (obs_dones.size() != 1 || obs_dones[0] != obs_acc[0] + DW) begin
                bad++;
                $display("FAIL basic_bb_done got n=%0d req 1 at %0d", obs_dones.size(), obs_acc[0] + DW);
            end
        end
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL basic_bb_idle got busy=%b rdy=%b ovf=%b req 0", busy, in_ready, overflow);
        end
        frm_words = '{8'b1011_0110};
        run_frame(1, 1'b0);
        total++;
        if (obs_timeout || match_count !== 8'd1 || obs_pulses.size() != 1) begin
            bad++;
            $display("FAIL basic_b6 got cnt=%0d pulses=%0d req 1/1", match_count, obs_pulses.size());
        end
    endtask

`ifdef PATTERN_DET_OVERLAP_EN
    task automatic test_overlap;
        set_cfg(8'b0000_1011, 4, 1'b1);
        frm_words = '{8'b1011_0110};
        frm_gaps = '{0};
        run_frame(1, 1'b0);
        total++;
        if (obs_timeout || match_count !== 8'd2 || obs_pulses.size() != 2) begin
            bad++;
            $display("FAIL overlap_b6 got cnt=%0d pulses=%0d req 2/2", match_count, obs_pulses.size());
        end else if (obs_pulses[1] != obs_acc[0] + 7) begin
            bad++;
            $display("FAIL overlap_b6_pulse got %0d req %0d", obs_pulses[1], obs_acc[0] + 7);
        end
    endtask
`endif

    task automatic test_cross_word;
        set_cfg(8'b0000_1011, 4, 1'b0);
        frm_words = '{8'b0000_0101, 8'b1000_0000};
        frm_gaps = '{0, 3};
        run_frame(2, 1'b1);
        total++;
        if (obs_timeout || obs_acc.size() != 2) begin
            bad++;
            $display("FAIL cross_run timeout=%b acc=%0d req 0/2", obs_timeout, obs_acc.size());
        end else begin
            total++;
            if (obs_acc[1] - obs_acc[0] != DW + 1 + 3) begin
                bad++;
                $display("FAIL cross_stall got gap=%0d req %0d", obs_acc[1] - obs_acc[0], DW + 4);
            end
            total++;
            if (match_count !== 8'd1 || obs_pulses.size() != 1 || obs_pulses[0] != obs_acc[1] + 1) begin
                bad++;
                $display("FAIL cross_match got cnt=%0d pulses=%0d req 1 at %0d", match_count,
                         obs_pulses.size(), obs_acc[1] + 1);
            end
        end
    endtask

    task automatic test_boundaries;
        frm_words.delete();
        frm_gaps.delete();
        run_frame(0, 1'b0);
        total++;
        if (obs_timeout || obs_dones.size() != 1 || obs_dones[0] != 1 || match_count !== 8'd0) begin
            bad++;
            $display("FAIL flen0 got dones=%0d cnt=%0d req done at 1 cnt=0", obs_dones.size(), match_count);
        end
        for (int l = 0; l <= 9; l += 9) begin
            set_cfg(8'hFF, l, 1'b0);
            frame_len = 1;
            start = 1'b1;
            tick();
            start = 1'b0;
            tick();
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL badlen%0d got busy=%b req 0", l, busy);
            end
        end
        set_cfg(8'b0000_1011, 4, 1'b0);
        frame_len = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hBB;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle got busy=%b rdy=%b req 0/0", busy, in_ready);
        end
        begin
            int nd = 0;
            for (int i = 0; i < 15; i++) begin
                if (done) nd++;
                tick();
            end
            total++;
            if (nd != 0 || match_count !== 8'd1) begin
                bad++;
                $display("FAIL abort_frozen got dones=%0d cnt=%0d req 0/1", nd, match_count);
            end
        end
    endtask

    task automatic test_saturation;
        set_cfg(8'b0000_0001, 1, 1'b0);
        frm_words.delete();
        frm_gaps.delete();
        for (int i = 0; i < 32; i++) begin
            frm_words.push_back(8'hFF);
            frm_gaps.push_back(0);
        end
        run_frame(32, 1'b0);
        total++;
        if (obs_timeout || match_count !== 8'd255 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL sat got cnt=%0d ovf=%b req 255/1", match_count, overflow);
        end
        total++;
        if (obs_dones.size() != 1 || obs_pulses.size() != 256) begin
            bad++;
            $display("FAIL sat_pulses got dones=%0d pulses=%0d req 1/256", obs_dones.size(), obs_pulses.size());
        end
    endtask

    task automatic test_random;
        for (int f = 0; f < 30; f++) begin
            int flen;
            bit ok;
            set_cfg(PW'($urandom), $urandom_range(1, $urandom_range(1, PW)), 1'($urandom));
            flen = $urandom_range(1, 4);
            frm_words.delete();
            frm_gaps.delete();
            for (int i = 0; i < flen; i++) begin
                frm_words.push_back(DW'($urandom));
                frm_gaps.push_back($urandom_range(0, 3));
            end
            model(flen);
            run_frame(flen, 1'($urandom));
            total++;
            if (obs_timeout || obs_busy_bad || obs_dones.size() != 1 || obs_acc.size() != flen) begin
                bad++;
                $display("FAIL rand%0d_frame timeout=%b busy_bad=%b dones=%0d acc=%0d req 0/0/1/%0d",
                         f, obs_timeout, obs_busy_bad, obs_dones.size(), obs_acc.size(), flen);
                continue;
            end
            total++;
            if (match_count !== CW'(exp_cnt) || overflow !== exp_ovf) begin
                bad++;
                $display("FAIL rand%0d_count got cnt=%0d ovf=%b req %0d/%b", f, match_count,
                         overflow, exp_cnt, exp_ovf);
            end
            ok = (obs_pulses.size() == exp_bits.size());
            if (ok)
                foreach (exp_bits[j])
                    if (obs_pulses[j] != obs_acc[exp_bits[j] / DW] + 1 + exp_bits[j] % DW) ok = 1'b0;
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL rand%0d_pulses got n=%0d req n=%0d", f, obs_pulses.size(), exp_bits.size());
            end
            ok = (obs_acc[0] == 2 + frm_gaps[0]) && (obs_dones[0] == obs_acc[flen-1] + DW);
            for (int w = 1; w < flen; w++)
                if (obs_acc[w] - obs_acc[w-1] != DW + 1 + frm_gaps[w]) ok = 1'b0;
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL rand%0d_timing got first=%0d done=%0d req first=%0d", f, obs_acc[0],
                         obs_dones[0], 2 + frm_gaps[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef PATTERN_DET_OVERLAP_EN
        test_overlap();
`endif
        test_cross_word();
        test_boundaries();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
